// File: rtl/fc_layer_sequencer_if.sv
// Bus bundle between the FC layer sequencer, the FC engine and the system output.
// Optional macro: FC_ARGMAX_EN adds the winning-class outputs (class_o, class_valid_o).
interface fc_layer_sequencer_if;
    logic       go_i;
    logic [7:0] fc_result_i;
    logic       fc_valid_i;
    logic       fc_last_i;
    logic       start_o;
    logic [1:0] nth_fully_o;
    logic [8:0] in_node_num_o;
    logic [6:0] out_node_num_o;
    logic       ifmap_wren_o;
    logic [9:0] ifmap_wrptr_o;
    logic [7:0] ifmap_wdata_o;
    logic [7:0] res_data_o;
    logic       res_valid_o;
    logic       res_last_o;
    logic       busy_o;
    logic       err_o;
`ifdef FC_ARGMAX_EN
    logic [3:0] class_o;
    logic       class_valid_o;

    modport master (
        input  go_i, fc_result_i, fc_valid_i, fc_last_i,
        output start_o, nth_fully_o, in_node_num_o, out_node_num_o,
        output ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o,
        output res_data_o, res_valid_o, res_last_o, busy_o, err_o,
        output class_o, class_valid_o
    );
    modport slave (
        output go_i, fc_result_i, fc_valid_i, fc_last_i,
        input  start_o, nth_fully_o, in_node_num_o, out_node_num_o,
        input  ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o,
        input  res_data_o, res_valid_o, res_last_o, busy_o, err_o,
        input  class_o, class_valid_o
    );
`else
    modport master (
        input  go_i, fc_result_i, fc_valid_i, fc_last_i,
        output start_o, nth_fully_o, in_node_num_o, out_node_num_o,
        output ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o,
        output res_data_o, res_valid_o, res_last_o, busy_o, err_o
    );
    modport slave (
        output go_i, fc_result_i, fc_valid_i, fc_last_i,
        input  start_o, nth_fully_o, in_node_num_o, out_node_num_o,
        input  ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o,
        input  res_data_o, res_valid_o, res_last_o, busy_o, err_o
    );
`endif
endinterface

// File: rtl/fc_layer_sequencer.sv
// Chains the FC layers: stages each non-final layer's outputs, copies them into the
// engine ifmap buffer, restarts the engine on the next layer, and forwards the final
// layer to the system output.
// Optional macro: FC_ARGMAX_EN adds winning-class tracking on the final layer.
//
// state | meaning
// IDLE  | waiting for go_i
// START | one-cycle engine start pulse, layer config already stable
// RUN   | engine streaming results (staged, or forwarded on the final layer)
// COPY  | staging RAM -> ifmap buffer; first write lands two cycles after the
//       | fc_last_i beat (one cycle for the synchronous RAM read)
// GAP   | one quiet cycle before the next layer's start
module fc_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int L0_IN      = 128,
    parameter int L0_OUT     = 120,
    parameter int L1_OUT     = 84,
    parameter int L2_OUT     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    fc_layer_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_COPY, S_GAP} state_t;

    state_t     state_q, state_d;
    logic [1:0] layer_q, layer_d;
    logic       load_cfg;
    logic [1:0] nth_q;
    logic [8:0] in_n_q;
    logic [6:0] out_n_q;
    logic [7:0] beat_cnt_q;
    logic [7:0] copy_cnt_q;
    logic       err_q;
    logic       wren_q;
    logic [9:0] wrptr_q;
    logic [7:0] rd_data_q;
    logic [7:0] res_data_q;
    logic       res_valid_q;
    logic       res_last_q;
    logic [7:0] stage_mem [0:127];

    logic final_layer, run_beat, end_beat, beat_in_range, beat_at_end, copy_done, take_res;

    function automatic logic [8:0] in_nodes(input logic [1:0] l);
        case (l)
            2'd0:    return 9'(L0_IN);
            2'd1:    return 9'(L0_OUT);
            default: return 9'(L1_OUT);
        endcase
    endfunction

    function automatic logic [6:0] out_nodes(input logic [1:0] l);
        case (l)
            2'd0:    return 7'(L0_OUT);
            2'd1:    return 7'(L1_OUT);
            default: return 7'(L2_OUT);
        endcase
    endfunction

    assign final_layer   = (layer_q == 2'(NUM_LAYERS - 1));
    assign run_beat      = (state_q == S_RUN) && bus.fc_valid_i;
    assign end_beat      = run_beat && bus.fc_last_i;
    assign beat_in_range = (beat_cnt_q < {1'b0, out_n_q});
    assign beat_at_end   = (beat_cnt_q == ({1'b0, out_n_q} - 8'd1));
    assign copy_done     = (copy_cnt_q == {1'b0, out_n_q});
    assign take_res      = run_beat && final_layer && beat_in_range;

    // state and layer index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= 2'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
        end
    end

    // next-state logic; config is loaded on every entry into START
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        load_cfg = 1'b0;
        case (state_q)
            S_IDLE: if (bus.go_i) begin
                state_d  = S_START;
                layer_d  = 2'd0;
                load_cfg = 1'b1;
            end
            S_START: state_d = S_RUN;
            S_RUN:   if (end_beat) state_d = final_layer ? S_IDLE : S_COPY;
            S_COPY:  if (copy_done) state_d = S_GAP;
            S_GAP: begin
                state_d  = S_START;
                layer_d  = layer_q + 2'd1;
                load_cfg = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // layer configuration outputs, held from START until the next chain
    always_ff @(posedge clk) begin
        if (rst) begin
            nth_q   <= 2'd0;
            in_n_q  <= 9'd0;
            out_n_q <= 7'd0;
        end else if (load_cfg) begin
            nth_q   <= layer_d;
            in_n_q  <= in_nodes(layer_d);
            out_n_q <= out_nodes(layer_d);
        end
    end

    // beat index within the current layer; saturates so runaway streams stay out of range
    always_ff @(posedge clk) begin
        if (rst || state_q == S_START) beat_cnt_q <= 8'd0;
        else if (run_beat && beat_cnt_q != 8'hff) beat_cnt_q <= beat_cnt_q + 8'd1;
    end

    // sticky node-count error, cleared when a new chain is accepted
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (state_q == S_IDLE && bus.go_i) err_q <= 1'b0;
        else if (run_beat && (!beat_in_range || (bus.fc_last_i && !beat_at_end))) err_q <= 1'b1;
    end

    // staging RAM write port (non-final layers only)
    always_ff @(posedge clk) begin
        if (run_beat && !final_layer && beat_in_range) stage_mem[beat_cnt_q[6:0]] <= bus.fc_result_i;
    end

    // staging RAM synchronous read, addressed by the copy counter
    always_ff @(posedge clk) begin
        rd_data_q <= stage_mem[copy_cnt_q[6:0]];
    end

    // copy address issue and the write strobe/address delayed to meet the read data
    always_ff @(posedge clk) begin
        if (rst) begin
            copy_cnt_q <= 8'd0;
            wren_q     <= 1'b0;
            wrptr_q    <= 10'd0;
        end else begin
            if (state_q != S_COPY) copy_cnt_q <= 8'd0;
            else if (!copy_done)   copy_cnt_q <= copy_cnt_q + 8'd1;
            wren_q  <= (state_q == S_COPY) && !copy_done;
            wrptr_q <= {2'b00, copy_cnt_q};
        end
    end

    // final-layer pass-through, one register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q  <= 8'd0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            res_valid_q <= take_res;
            res_last_q  <= take_res && bus.fc_last_i;
            if (take_res) res_data_q <= bus.fc_result_i;
        end
    end

`ifdef FC_ARGMAX_EN
    logic signed [7:0] max_val_q;
    logic [3:0]        max_idx_q;
    logic [3:0]        class_q;
    logic              class_valid_q;
    logic              new_max;

    // strictly-greater compare keeps the lowest index on ties
    assign new_max = (beat_cnt_q == 8'd0) || ($signed(bus.fc_result_i) > max_val_q);

    // running maximum and winner latch on the final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q     <= 8'sd0;
            max_idx_q     <= 4'd0;
            class_q       <= 4'd0;
            class_valid_q <= 1'b0;
        end else begin
            class_valid_q <= 1'b0;
            if (state_q == S_IDLE && bus.go_i) class_q <= 4'd0;
            if (take_res) begin
                if (new_max) begin
                    max_val_q <= $signed(bus.fc_result_i);
                    max_idx_q <= beat_cnt_q[3:0];
                end
                if (bus.fc_last_i) begin
                    class_q       <= new_max ? beat_cnt_q[3:0] : max_idx_q;
                    class_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.class_o       = class_q;
    assign bus.class_valid_o = class_valid_q;
`else
    // final layer is a plain stream pass-through; no winner tracking
`endif

    assign bus.start_o        = (state_q == S_START);
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.err_o          = err_q;
    assign bus.nth_fully_o    = nth_q;
    assign bus.in_node_num_o  = in_n_q;
    assign bus.out_node_num_o = out_n_q;
    assign bus.ifmap_wren_o   = wren_q;
    assign bus.ifmap_wrptr_o  = wrptr_q;
    assign bus.ifmap_wdata_o  = wren_q ? rd_data_q : 8'd0;
    assign bus.res_data_o     = res_data_q;
    assign bus.res_valid_o    = res_valid_q;
    assign bus.res_last_o     = res_last_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: expected ifmap writes, starts, final
// results (and the winning class with FC_ARGMAX_EN) are queued with their cycle.
module tb_fc_layer_sequencer;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_layer_sequencer_if bus();

    fc_layer_sequencer #(.NUM_LAYERS(NL), .L0_IN(128), .L0_OUT(120), .L1_OUT(84), .L2_OUT(10))
        dut (.clk(clk), .rst(rst), .bus(bus.master));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct { logic [9:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic [1:0] nth; logic [8:0] inn; logic [6:0] outn; int cyc; } st_t;
    typedef struct { logic [7:0] data; logic lst; int cyc; } res_t;
    typedef struct { logic [3:0] cls; int cyc; } cls_t;

    wr_t  wr_q[$];
    st_t  st_q[$];
    res_t res_q[$];
    cls_t cls_q[$];
    logic [7:0] m_stage [128];

    function automatic int out_of(input int l);
        case (l)
            0: return 120;
            1: return 84;
            2: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int in_of(input int l);
        case (l)
            0: return 128;
            1: return 120;
            2: return 84;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] beat_val(input int kind, input int i);
        case (kind)
            0: return 8'(i);
            1: return 8'(3 * i + 1);
            2: case (i)
                   0: return 8'hFD;
                   1: return 8'd7;
                   2: return 8'd2;
                   3: return 8'd7;
                   default: return 8'd0;
               endcase
            3: case (i)
                   0: return 8'd5;
                   1: return 8'hFF;
                   2: return 8'd9;
                   3: return 8'd9;
                   9: return 8'h80;
                   default: return 8'd0;
               endcase
            4: return 8'(i + 7);
            default: return 8'(5 * i);
        endcase
    endfunction

    // output monitor: pop and compare every DUT event against the scoreboard
    wr_t  mw;
    st_t  ms;
    res_t mr;
    cls_t mc;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.start_o && bus.ifmap_wren_o) chk("wren_start_overlap", 1, 0);
            if (bus.start_o) begin
                if (st_q.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    ms = st_q.pop_front();
                    chk("start_nth", 32'(bus.nth_fully_o), 32'(ms.nth));
                    chk("start_in", 32'(bus.in_node_num_o), 32'(ms.inn));
                    chk("start_out", 32'(bus.out_node_num_o), 32'(ms.outn));
                    chk("start_cyc", cyc, ms.cyc);
                end
            end
            if (bus.ifmap_wren_o) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", 32'(bus.ifmap_wrptr_o), 32'(mw.addr));
                    chk("wr_data", 32'(bus.ifmap_wdata_o), 32'(mw.data));
                    chk("wr_cyc", cyc, mw.cyc);
                end
            end
            if (bus.res_valid_o) begin
                if (res_q.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    mr = res_q.pop_front();
                    chk("res_data", 32'(bus.res_data_o), 32'(mr.data));
                    chk("res_last", 32'(bus.res_last_o), 32'(mr.lst));
                    chk("res_cyc", cyc, mr.cyc);
                end
            end
`ifdef FC_ARGMAX_EN
            if (bus.class_valid_o) begin
                if (cls_q.size() == 0) chk("class_unexpected", 1, 0);
                else begin
                    mc = cls_q.pop_front();
                    chk("class", 32'(bus.class_o), 32'(mc.cls));
                    chk("class_cyc", cyc, mc.cyc);
                end
            end
`endif
        end
    end

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.go_i = 1'b0;
        bus.fc_valid_i = 1'b0;
        bus.fc_last_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        @(negedge clk);
        chk({pfx, "_ctl"}, 32'({bus.start_o, bus.busy_o, bus.err_o, bus.ifmap_wren_o,
                                bus.res_valid_o, bus.res_last_o}), 0);
        chk({pfx, "_cfg"}, 32'({bus.nth_fully_o, bus.in_node_num_o, bus.out_node_num_o}), 0);
        chk({pfx, "_wr"}, 32'({bus.ifmap_wrptr_o, bus.ifmap_wdata_o}), 0);
        chk({pfx, "_res"}, 32'(bus.res_data_o), 0);
`ifdef FC_ARGMAX_EN
        chk({pfx, "_class"}, 32'({bus.class_o, bus.class_valid_o}), 0);
`endif
    endtask

    task automatic pulse_go();
        @(posedge clk); #1;
        bus.go_i = 1'b1;
        st_q.push_back(st_t'{2'd0, 9'd128, 7'd120, cyc + 1});
        @(posedge clk); #1;
        bus.go_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.start_o) seen = 1'b1;
        end
        if (!seen) chk(tag, 0, 1);
    endtask

    task automatic run_layer(input int layer, input int n_beats, input int kind,
                             input bit with_last, input int go_at);
        int out_n = out_of(layer);
        bit fin = (layer == NL - 1);
        logic signed [7:0] mx = 8'sd0;
        int mi = 0;
        logic [7:0] v;
        for (int i = 0; i < n_beats; i++) begin
            @(posedge clk); #1;
            v = beat_val(kind, i);
            bus.fc_valid_i  = 1'b1;
            bus.fc_result_i = v;
            bus.fc_last_i   = with_last && (i == n_beats - 1);
            bus.go_i        = (i == go_at);
            if (i < out_n) begin
                if (fin) begin
                    res_q.push_back(res_t'{v, bus.fc_last_i, cyc + 1});
                    if (i == 0 || $signed(v) > mx) begin
                        mx = $signed(v);
                        mi = i;
                    end
                end else begin
                    m_stage[i] = v;
                end
            end
            if (bus.fc_last_i) begin
                if (fin) begin
`ifdef FC_ARGMAX_EN
                    cls_q.push_back(cls_t'{4'(mi), cyc + 1});
`endif
                end else begin
                    for (int k = 0; k < out_n; k++)
                        wr_q.push_back(wr_t'{10'(k), m_stage[k], cyc + 2 + k});
                    st_q.push_back(st_t'{2'(layer + 1), 9'(in_of(layer + 1)),
                                         7'(out_of(layer + 1)), cyc + 3 + out_n});
                end
            end
        end
        @(posedge clk); #1;
        bus.fc_valid_i = 1'b0;
        bus.fc_last_i  = 1'b0;
        bus.go_i       = 1'b0;
        if (fin && with_last) begin
            @(negedge clk);
            chk("busy_after_last", 32'(bus.busy_o), 0);
            chk("res_last_at_idle", 32'(bus.res_last_o), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.go_i = 1'b0;
        bus.fc_result_i = 8'd0;
        bus.fc_valid_i = 1'b0;
        bus.fc_last_i = 1'b0;
        for (int i = 0; i < 128; i++) m_stage[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 32'({bus.start_o, bus.busy_o, bus.err_o, bus.ifmap_wren_o,
                            bus.res_valid_o, bus.res_last_o}), 0);
        chk("rst_cfg", 32'({bus.nth_fully_o, bus.in_node_num_o, bus.out_node_num_o}), 0);

        // reset in the middle of layer 0
        pulse_go();
        wait_start("start0_t1");
        run_layer(0, 30, 4, 1'b0, -1);
        pulse_rst();
        chk_zero("midrun_rst");

        // full clean chain
        pulse_go();
        wait_start("start0_t2");
        run_layer(0, 120, 0, 1'b1, -1);
        wait_start("start1_t2");
        chk("err_clean_l0", 32'(bus.err_o), 0);
        run_layer(1, 84, 1, 1'b1, -1);
        wait_start("start2_t2");
        run_layer(2, 10, 2, 1'b1, -1);
        chk("err_clean_chain", 32'(bus.err_o), 0);

        // short layer 0: fc_last on beat 99
        pulse_go();
        wait_start("start0_t3");
        run_layer(0, 100, 4, 1'b1, -1);
        wait_start("start1_t3");
        chk("err_short", 32'(bus.err_o), 1);
        pulse_rst();

        // long layer 0 with a stray go_i, then finish the chain
        pulse_go();
        wait_start("start0_t4");
        run_layer(0, 125, 5, 1'b1, 50);
        wait_start("start1_t4");
        chk("err_long", 32'(bus.err_o), 1);
        run_layer(1, 84, 1, 1'b1, -1);
        wait_start("start2_t4");
        run_layer(2, 10, 3, 1'b1, -1);
        chk("err_sticky", 32'(bus.err_o), 1);
        pulse_go();
        wait_start("start0_t5");
        chk("err_clr_on_go", 32'(bus.err_o), 0);
        pulse_rst();
        repeat (3) @(posedge clk);

        chk("sb_wr_drain", wr_q.size(), 0);
        chk("sb_start_drain", st_q.size(), 0);
        chk("sb_res_drain", res_q.size(), 0);
        chk("sb_class_drain", cls_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Chains the fully-connected layers of the classifier. Sits directly downstream of the FC engine top: it consumes the engine's result stream, stages one layer's output nodes in a local buffer, and copies them into the engine's ifmap buffer through the ifmap write port. It then issues the next layer's start with the matching layer index and node counts. On the final layer it forwards results to the system output and optionally computes the winning class.

## Interface
Parameters:
- NUM_LAYERS, 3, number of chained FC layers (2..3)
- L0_IN, 128, input nodes of layer 0 (the caller has already filled the ifmap buffer for it)
- L0_OUT, 120, output nodes of layer 0, which are also the input nodes of layer 1
- L1_OUT, 84, output nodes of layer 1
- L2_OUT, 10, output nodes of layer 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- go_i  in  1  one-cycle pulse: the layer-0 weight and ifmap buffers are filled
- fc_result_i  in  8  engine output node value (signed)
- fc_valid_i  in  1  fc_result_i is valid
- fc_last_i  in  1  last output node of the current layer; qualified by fc_valid_i
- start_o  out  1  one-cycle start pulse to the engine
- nth_fully_o  out  2  current layer index
- in_node_num_o  out  9  input node count of the current layer
- out_node_num_o  out  7  output node count of the current layer
- ifmap_wren_o  out  1  ifmap buffer write enable
- ifmap_wrptr_o  out  10  ifmap buffer write address
- ifmap_wdata_o  out  8  ifmap buffer write data
- res_data_o  out  8  final-layer output node value
- res_valid_o  out  1  res_data_o is valid
- res_last_o  out  1  last final-layer output node
- class_o  out  4  index of the winning class (present only with FC_ARGMAX_EN)
- class_valid_o  out  1  class_o is valid (present only with FC_ARGMAX_EN)
- busy_o  out  1  a chain is in progress
- err_o  out  1  sticky node-count mismatch flag; cleared by go_i or rst

## Operation
- States: IDLE, START, RUN, COPY, GAP.
- IDLE: on go_i, clear err_o, set layer to 0, go to START. A go_i received in any other state is ignored.
- START: assert start_o for one cycle, then go to RUN.
  - nth_fully_o, in_node_num_o and out_node_num_o are driven from the layer index.
  - Per layer: layer 0 is L0_IN/L0_OUT; layer 1 is L0_OUT/L1_OUT; layer 2 is L1_OUT/L2_OUT.
  - These outputs stay stable from START until the chain returns to IDLE.
- RUN, non-final layer: each beat with fc_valid_i writes fc_result_i into local staging RAM (128x8) at the index given by a beat counter, then increments the counter.
  - A beat with index >= the layer's OUT is dropped and sets err_o.
  - A beat carrying fc_last_i ends the layer and moves to COPY. If the counter is not OUT-1 on that beat, set err_o.
- RUN, final layer (layer NUM_LAYERS-1): staging is bypassed.
  - res_data_o, res_valid_o and res_last_o are registered copies of the inputs (one-cycle latency).
  - The beat carrying fc_last_i returns the block to IDLE.
  - Count checking applies as above.
- COPY: for k = 0..OUT-1, one per cycle, drive ifmap_wren_o=1, ifmap_wrptr_o=k, ifmap_wdata_o=staging[k].
  - Staging RAM reads are synchronous. Account for the read latency so that the data and address are aligned on the same cycle.
- GAP: one idle cycle, then increment the layer index and go to START.
- busy_o is 1 in every state except IDLE.
- Reset in any state forces IDLE and drives all outputs to 0. The staging RAM contents are don't-care after reset.

## Timing
- Reset values: every output is 0.
- go_i at cycle t gives start_o at t+1.
- fc_last_i beat at cycle t (non-final layer): the first ifmap write is at t+1 or t+2 (fixed by the implementation and documented). Writes are contiguous for OUT cycles, GAP follows, then start_o.
- ifmap_wren_o never overlaps start_o.
- fc_valid_i while not in RUN is ignored.
- Final-layer result: res_valid_o asserts exactly one cycle after the corresponding fc_valid_i.

## Configuration
- FC_ARGMAX_EN, when defined:
  - During the final layer, track the maximum signed fc_result_i and its beat index.
  - Ties are won by the strictly-greater comparison, so the lowest index keeps the win.
  - class_valid_o pulses for one cycle, coincident with res_last_o.
  - class_o holds its value until the next go_i or rst.
- Not defined: class_o and class_valid_o and the argmax logic are absent. The final layer is stream pass-through only.

## Test plan
- Reset in RUN mid-layer: all outputs read 0 on the next cycle; a following go_i starts cleanly at layer 0.
- go_i, engine returns 120 beats with fc_last_i on beat 119 (values k):
  - 120 ifmap writes with addr k and data k, then start_o with nth_fully_o=1, in_node_num_o=120, out_node_num_o=84.
  - err_o stays 0.
- Full 3-layer chain, final layer values -3,7,2,7,0,0,0,0,0,0:
  - 10 res_valid_o beats; res_last_o on the 10th beat.
  - busy_o drops after the 10th beat.
  - With FC_ARGMAX_EN: class_o=1 and class_valid_o coincident with res_last_o.
- Layer 0, fc_last_i arrives on beat 99 (100 beats): err_o=1, and COPY still writes 120 entries.
- Layer 0, 125 beats: beats 120..124 produce no ifmap writes and err_o=1. A go_i pulsed during RUN has no effect.
